// File: rtl/lsu_pkg.sv
// Shared definitions for the SISC load/store unit: state encoding, default
// geometry and the opcodes ctrl decodes into start/is_store.
package lsu_pkg;

  localparam int DEF_AW      = 16;
  localparam int DEF_DW      = 32;
  localparam int DEF_TIMEOUT = 15;

  // Memory-class opcodes; ctrl raises start on either and is_store on OP_ST.
  localparam logic [3:0] OP_LD = 4'h8;
  localparam logic [3:0] OP_ST = 4'h9;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DONE = 2'd2
  } lsu_state_e;

endpackage

// File: rtl/lsu_if.sv
// Data-memory request/acknowledge bus between the LSU (master) and memory.
interface lsu_if
  import lsu_pkg::*;
#(
  parameter int AW = DEF_AW,
  parameter int DW = DEF_DW
);
  // dm_req is held until dm_ack or abort; dm_we/dm_addr/dm_wdata are stable
  // for the whole time dm_req is high; dm_rdata is valid with dm_ack on a load.
  logic          dm_req;
  logic          dm_we;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata;
  logic          dm_ack;
  logic [DW-1:0] dm_rdata;

  modport master (
    output dm_req, dm_we, dm_addr, dm_wdata,
    input  dm_ack, dm_rdata
  );

  modport slave (
    input  dm_req, dm_we, dm_addr, dm_wdata,
    output dm_ack, dm_rdata
  );
endinterface

// File: rtl/lsu.sv
// SISC load/store unit: one memory transaction per start pulse, with range
// check on the ALU address and a bounded wait for the memory acknowledge.
module lsu
  import lsu_pkg::*;
#(
  parameter int AW      = DEF_AW,
  parameter int DW      = DEF_DW,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          is_store,
  input  logic [31:0]   addr,
  input  logic [DW-1:0] wdata,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [DW-1:0] ld_data,
  output lsu_state_e    state,
  lsu_if.master         dm
);

  localparam logic [7:0] ABORT_AT = 8'(TIMEOUT - 1);

  lsu_state_e state_next;
  logic [7:0] wait_cnt;
  logic       range_ok;
  logic       accept;
  logic       abort;

  // Address bits above the data-memory word range must all be zero.
  assign range_ok = (addr >> AW) == 32'd0;
  assign accept   = (state == S_IDLE) && start;
  assign abort    = (state == S_REQ) && !dm.dm_ack && (wait_cnt == ABORT_AT);

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (start) state_next = range_ok ? S_REQ : S_DONE;
      S_REQ:   if (dm.dm_ack || abort) state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);
  assign dm.dm_req = (state == S_REQ);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      err         <= 1'b0;
      ld_data     <= '0;
      wait_cnt    <= '0;
      dm.dm_we    <= 1'b0;
      dm.dm_addr  <= '0;
      dm.dm_wdata <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        err         <= !range_ok;
        wait_cnt    <= '0;
        dm.dm_we    <= is_store;
        dm.dm_addr  <= addr[AW-1:0];
        dm.dm_wdata <= wdata;
      end else if (state == S_REQ) begin
        // An ack in the abort cycle still completes the transaction cleanly.
        if (dm.dm_ack) begin
          if (!dm.dm_we) ld_data <= dm.dm_rdata;
        end else if (abort) begin
          err <= 1'b1;
        end else begin
          wait_cnt <= wait_cnt + 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu with TIMEOUT=4: loads, stores, wait states, timeout,
// range fault, ack on the abort cycle and reset during a request.
module tb_lsu;
  import lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        is_store = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        busy, done, err;
  logic [31:0] ld_data;
  lsu_state_e  state;
  int          checks = 0;
  int          errors = 0;

  lsu_if #(.AW(16), .DW(32)) dm_bus ();

  lsu #(.AW(16), .DW(32), .TIMEOUT(4)) u_dut (
    .clk(clk), .rst(rst), .start(start), .is_store(is_store), .addr(addr),
    .wdata(wdata), .busy(busy), .done(done), .err(err), .ld_data(ld_data),
    .state(state), .dm(dm_bus.master)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge clk);
  endtask

  // Pulses start for cycle 0 and returns at the sampling point of cycle 1.
  task automatic issue(input logic st, input logic [31:0] a, input logic [31:0] d);
    start = 1'b1; is_store = st; addr = a; wdata = d;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    dm_bus.dm_ack = 1'b0; dm_bus.dm_rdata = '0;
    tick(); tick();
    checks++; if (state !== S_IDLE) begin errors++; $display("FAIL rst_state: got %0d want 0", state); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done: got %b want 0", done); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL rst_err: got %b want 0", err); end
    checks++; if (ld_data !== 32'h0) begin errors++; $display("FAIL rst_ld_data: got %h want 0", ld_data); end
    checks++; if (dm_bus.dm_req !== 1'b0) begin errors++; $display("FAIL rst_req: got %b want 0", dm_bus.dm_req); end
    checks++; if (dm_bus.dm_we !== 1'b0) begin errors++; $display("FAIL rst_we: got %b want 0", dm_bus.dm_we); end
    checks++; if (dm_bus.dm_addr !== 16'h0) begin errors++; $display("FAIL rst_addr: got %h want 0", dm_bus.dm_addr); end
    checks++; if (dm_bus.dm_wdata !== 32'h0) begin errors++; $display("FAIL rst_wdata: got %h want 0", dm_bus.dm_wdata); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_load_first_ack();
    issue(1'b0, 32'h0000_0010, 32'h0);
    checks++; if (dm_bus.dm_req !== 1'b1) begin errors++; $display("FAIL ld_req_c1: got %b want 1", dm_bus.dm_req); end
    checks++; if (dm_bus.dm_addr !== 16'h0010) begin errors++; $display("FAIL ld_addr_c1: got %h want 0010", dm_bus.dm_addr); end
    checks++; if (dm_bus.dm_we !== 1'b0) begin errors++; $display("FAIL ld_we_c1: got %b want 0", dm_bus.dm_we); end
    checks++; if (busy !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL ld_busy_c1: got busy=%b done=%b want 1/0", busy, done); end
    dm_bus.dm_ack = 1'b1; dm_bus.dm_rdata = 32'hDEAD_BEEF;
    tick();
    dm_bus.dm_ack = 1'b0; dm_bus.dm_rdata = '0;
    checks++; if (done !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL ld_done_c2: got done=%b busy=%b want 1/1", done, busy); end
    checks++; if (dm_bus.dm_req !== 1'b0) begin errors++; $display("FAIL ld_req_c2: got %b want 0", dm_bus.dm_req); end
    checks++; if (ld_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL ld_data_c2: got %h want deadbeef", ld_data); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL ld_err_c2: got %b want 0", err); end
    tick();
    checks++; if (state !== S_IDLE || busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL ld_idle_c3: got state=%0d busy=%b done=%b want 0/0/0", state, busy, done); end
  endtask

  task automatic test_store_wait();
    issue(1'b1, 32'h0000_0020, 32'h1234_5678);
    for (int c = 1; c <= 4; c++) begin
      checks++; if (dm_bus.dm_req !== 1'b1 || dm_bus.dm_we !== 1'b1) begin errors++; $display("FAIL st_req_c%0d: got req=%b we=%b want 1/1", c, dm_bus.dm_req, dm_bus.dm_we); end
      checks++; if (dm_bus.dm_wdata !== 32'h1234_5678 || dm_bus.dm_addr !== 16'h0020) begin errors++; $display("FAIL st_bus_c%0d: got addr=%h wdata=%h want 0020/12345678", c, dm_bus.dm_addr, dm_bus.dm_wdata); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL st_done_early_c%0d: got %b want 0", c, done); end
      if (c == 4) begin dm_bus.dm_ack = 1'b1; dm_bus.dm_rdata = 32'h5555_AAAA; end
      tick();
    end
    dm_bus.dm_ack = 1'b0;
    checks++; if (done !== 1'b1 || err !== 1'b0) begin errors++; $display("FAIL st_done_c5: got done=%b err=%b want 1/0", done, err); end
    checks++; if (ld_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL st_ld_keep: got %h want deadbeef", ld_data); end
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL st_idle_c6: got busy=%b want 0", busy); end
  endtask

  task automatic test_timeout();
    issue(1'b0, 32'h0000_0030, 32'h0);
    for (int c = 1; c <= 4; c++) begin
      checks++; if (dm_bus.dm_req !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL to_req_c%0d: got req=%b done=%b want 1/0", c, dm_bus.dm_req, done); end
      tick();
    end
    checks++; if (done !== 1'b1 || err !== 1'b1 || dm_bus.dm_req !== 1'b0) begin errors++; $display("FAIL to_done_c5: got done=%b err=%b req=%b want 1/1/0", done, err, dm_bus.dm_req); end
    checks++; if (ld_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL to_ld_keep: got %h want deadbeef", ld_data); end
    tick();
    checks++; if (state !== S_IDLE || err !== 1'b1) begin errors++; $display("FAIL to_sticky_c6: got state=%0d err=%b want 0/1", state, err); end
    issue(1'b0, 32'h0000_0040, 32'h0);
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL to_err_clear: got %b want 0", err); end
    dm_bus.dm_ack = 1'b1; dm_bus.dm_rdata = 32'hCAFE_F00D;
    tick();
    dm_bus.dm_ack = 1'b0;
    checks++; if (ld_data !== 32'hCAFE_F00D || done !== 1'b1) begin errors++; $display("FAIL to_next_load: got ld=%h done=%b want cafef00d/1", ld_data, done); end
    tick();
  endtask

  task automatic test_range_fault();
    issue(1'b0, 32'h0001_0000, 32'h0);
    checks++; if (dm_bus.dm_req !== 1'b0) begin errors++; $display("FAIL rf_req_c1: got %b want 0", dm_bus.dm_req); end
    checks++; if (done !== 1'b1 || err !== 1'b1) begin errors++; $display("FAIL rf_done_c1: got done=%b err=%b want 1/1", done, err); end
    start = 1'b1; is_store = 1'b1; addr = 32'h0000_0050; wdata = 32'h7777_7777;
    tick();
    start = 1'b0;
    checks++; if (state !== S_IDLE || dm_bus.dm_req !== 1'b0) begin errors++; $display("FAIL rf_ignore_c2: got state=%0d req=%b want 0/0", state, dm_bus.dm_req); end
    checks++; if (dm_bus.dm_addr !== 16'h0000 || dm_bus.dm_we !== 1'b0 || err !== 1'b1) begin errors++; $display("FAIL rf_latch_c2: got addr=%h we=%b err=%b want 0000/0/1", dm_bus.dm_addr, dm_bus.dm_we, err); end
    tick();
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL rf_idle_c3: got busy=%b done=%b want 0/0", busy, done); end
  endtask

  task automatic test_ack_on_abort();
    issue(1'b0, 32'h0000_0060, 32'h0);
    tick(); tick();
    dm_bus.dm_ack = 1'b0;
    tick();
    checks++; if (dm_bus.dm_req !== 1'b1) begin errors++; $display("FAIL ab_req_c4: got %b want 1", dm_bus.dm_req); end
    dm_bus.dm_ack = 1'b1; dm_bus.dm_rdata = 32'h0BAD_CAFE;
    tick();
    dm_bus.dm_ack = 1'b0;
    checks++; if (done !== 1'b1 || err !== 1'b0) begin errors++; $display("FAIL ab_done_c5: got done=%b err=%b want 1/0", done, err); end
    checks++; if (ld_data !== 32'h0BAD_CAFE) begin errors++; $display("FAIL ab_ld_c5: got %h want 0badcafe", ld_data); end
    tick();
    dm_bus.dm_ack = 1'b1; dm_bus.dm_rdata = 32'hFFFF_FFFF;
    tick(); tick();
    dm_bus.dm_ack = 1'b0;
    checks++; if (ld_data !== 32'h0BAD_CAFE || state !== S_IDLE || done !== 1'b0) begin errors++; $display("FAIL ab_spurious: got ld=%h state=%0d done=%b want 0badcafe/0/0", ld_data, state, done); end
  endtask

  task automatic test_reset_mid();
    issue(1'b0, 32'h0000_0070, 32'h0);
    checks++; if (dm_bus.dm_req !== 1'b1) begin errors++; $display("FAIL rm_req_c1: got %b want 1", dm_bus.dm_req); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (dm_bus.dm_req !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL rm_c2: got req=%b busy=%b done=%b want 0/0/0", dm_bus.dm_req, busy, done); end
    checks++; if (ld_data !== 32'h0 || err !== 1'b0) begin errors++; $display("FAIL rm_clear: got ld=%h err=%b want 0/0", ld_data, err); end
    tick();
    checks++; if (done !== 1'b0 || state !== S_IDLE) begin errors++; $display("FAIL rm_no_done: got done=%b state=%0d want 0/0", done, state); end
  endtask

  initial begin
    test_reset();
    test_load_first_ack();
    test_store_wait();
    test_timeout();
    test_range_fault();
    test_ack_on_abort();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
